// File: rtl/shift_register_universal_clkneg.sv
// Universal shift register clocked on the falling edge of ClkN, with an
// active-low enable, serial cascade ports and a saturating shift counter.
module shift_register_universal_clkneg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             ClkN,
    input  logic             Clr,
    input  logic             Enbar,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerInL,
    input  logic             SerInR,
    output logic [WIDTH-1:0] Q,
    output logic             SerOutL,
    output logic             SerOutR,
    output logic [CNT_W-1:0] ShiftCnt,
    output logic             Full
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_ASR  = 3'b110,
        M_CLR  = 3'b111
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    mode_t            mode;
    logic [WIDTH-1:0] q_next;
    logic             is_shift;
    logic             cnt_rst;

    assign mode = mode_t'(Mode);

    always_comb begin
        q_next   = Q;
        is_shift = 1'b0;
        cnt_rst  = 1'b0;
        unique case (mode)
            M_HOLD: q_next = Q;
            M_LOAD: begin
                q_next  = D;
                cnt_rst = 1'b1;
            end
            M_SHL: begin
                q_next   = {Q[WIDTH-2:0], SerInL};
                is_shift = 1'b1;
            end
            M_SHR: begin
                q_next   = {SerInR, Q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            M_ROL: begin
                q_next   = {Q[WIDTH-2:0], Q[WIDTH-1]};
                is_shift = 1'b1;
            end
            M_ROR: begin
                q_next   = {Q[0], Q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            M_ASR: begin
                q_next   = {Q[WIDTH-1], Q[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            M_CLR: begin
                q_next  = RESET_VALUE;
                cnt_rst = 1'b1;
            end
            default: q_next = Q;
        endcase
    end

    always_ff @(negedge ClkN or posedge Clr) begin
        if (Clr) begin
            Q        <= RESET_VALUE;
            ShiftCnt <= '0;
        end else if (!Enbar) begin
            Q <= q_next;
            // Counter saturates so Full stays asserted until a load or clear.
            if (cnt_rst)
                ShiftCnt <= '0;
            else if (is_shift && ShiftCnt != CNT_MAX)
                ShiftCnt <= ShiftCnt + CNT_W'(1);
        end
    end

    assign SerOutL = Q[WIDTH-1];
    assign SerOutR = Q[0];
    assign Full    = (ShiftCnt == CNT_MAX);

endmodule

// File: tb/tb_shift_register_universal_clkneg.sv
// Directed bench for the universal shift register: a default instance and a
// RESET_VALUE=8'h3C instance share all inputs.
module tb_shift_register_universal_clkneg;

    logic       ClkN = 1'b1;
    logic       Clr = 1'b0;
    logic       Enbar = 1'b1;
    logic [2:0] Mode = 3'b000;
    logic [7:0] D = 8'h00;
    logic       SerInL = 1'b0;
    logic       SerInR = 1'b0;

    logic [7:0] q_a, q_b;
    logic       sol_a, sor_a, full_a, sol_b, sor_b, full_b;
    logic [3:0] cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 ClkN = ~ClkN;

    shift_register_universal_clkneg #(.WIDTH(8), .RESET_VALUE(8'h00)) dut_a (
        .ClkN(ClkN), .Clr(Clr), .Enbar(Enbar), .Mode(Mode), .D(D),
        .SerInL(SerInL), .SerInR(SerInR), .Q(q_a), .SerOutL(sol_a),
        .SerOutR(sor_a), .ShiftCnt(cnt_a), .Full(full_a)
    );

    shift_register_universal_clkneg #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut_b (
        .ClkN(ClkN), .Clr(Clr), .Enbar(Enbar), .Mode(Mode), .D(D),
        .SerInL(SerInL), .SerInR(SerInR), .Q(q_b), .SerOutL(sol_b),
        .SerOutR(sor_b), .ShiftCnt(cnt_b), .Full(full_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one falling edge and settle before sampling.
    task automatic step();
        @(negedge ClkN);
        #1;
    endtask

    initial begin
        // Async reset between edges, while ClkN is high
        #2 Clr = 1'b1;
        #1;
        check("rst_q", 32'(q_a), 32'h00);
        check("rst_cnt", 32'(cnt_a), 0);
        check("rst_full", 32'(full_a), 0);
        check("rst_q_b", 32'(q_b), 32'h3C);
        @(posedge ClkN); #1 Clr = 1'b0;

        // Load and enable gating
        Enbar = 1'b0; Mode = 3'b001; D = 8'hA5;
        step();
        check("load_a5", 32'(q_a), 32'hA5);
        check("load_cnt", 32'(cnt_a), 0);
        Enbar = 1'b1; Mode = 3'b010; SerInL = 1'b1;
        step(); step(); step();
        check("gate_q", 32'(q_a), 32'hA5);
        check("gate_cnt", 32'(cnt_a), 0);

        // Logical shifts
        Enbar = 1'b0; Mode = 3'b010; SerInL = 1'b1;
        step();
        check("shl_q", 32'(q_a), 32'h4B);
        check("shl_cnt", 32'(cnt_a), 1);
        check("shl_serout_l", 32'(sol_a), 0);
        Mode = 3'b011; SerInR = 1'b0;
        step();
        check("shr_q", 32'(q_a), 32'h25);
        check("shr_cnt", 32'(cnt_a), 2);
        check("shr_serout_r", 32'(sor_a), 1);

        // Rotates
        Mode = 3'b001; D = 8'h81; step();
        Mode = 3'b100; step();
        check("rol_q", 32'(q_a), 32'h03);
        Mode = 3'b101; step();
        check("ror1_q", 32'(q_a), 32'h81);
        step();
        check("ror2_q", 32'(q_a), 32'hC0);
        check("ror_cnt", 32'(cnt_a), 3);

        // Arithmetic shift right
        Mode = 3'b001; D = 8'h80; step();
        Mode = 3'b110; step();
        check("asr1_q", 32'(q_a), 32'hC0);
        step();
        check("asr2_q", 32'(q_a), 32'hE0);
        check("asr_serout_l", 32'(sol_a), 1);

        // Saturation
        Mode = 3'b001; D = 8'hFF; step();
        Mode = 3'b010; SerInL = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("sat7_q", 32'(q_a), 32'h80);
        check("sat7_cnt", 32'(cnt_a), 7);
        check("sat7_full", 32'(full_a), 0);
        step();
        check("sat8_q", 32'(q_a), 32'h00);
        check("sat8_cnt", 32'(cnt_a), 8);
        check("sat8_full", 32'(full_a), 1);
        step();
        check("sat9_cnt", 32'(cnt_a), 8);
        check("sat9_full", 32'(full_a), 1);
        Mode = 3'b001; D = 8'h12; step();
        check("reload_q", 32'(q_a), 32'h12);
        check("reload_cnt", 32'(cnt_a), 0);
        check("reload_full", 32'(full_a), 0);

        // Clr pulsed mid shift sequence
        D = 8'h0F; step();
        Mode = 3'b010; SerInL = 1'b1;
        step();
        step();
        check("pre_clr_q", 32'(q_a), 32'h3F);
        check("pre_clr_cnt", 32'(cnt_a), 2);
        #1 Clr = 1'b1;
        #1;
        check("mid_clr_q", 32'(q_a), 32'h00);
        check("mid_clr_cnt", 32'(cnt_a), 0);
        check("mid_clr_q_b", 32'(q_b), 32'h3C);
        @(posedge ClkN); #1 Clr = 1'b0;
        Mode = 3'b001; D = 8'h5A;
        step();
        check("post_clr_load", 32'(q_a), 32'h5A);

        // Hold mode with enable active, then synchronous clear on both
        Mode = 3'b100; step();
        check("rol_b4", 32'(q_a), 32'hB4);
        Mode = 3'b000; step();
        check("hold_q", 32'(q_a), 32'hB4);
        check("hold_cnt", 32'(cnt_a), 1);
        Mode = 3'b111; step();
        check("sclr_q_a", 32'(q_a), 32'h00);
        check("sclr_q_b", 32'(q_b), 32'h3C);
        check("sclr_cnt_b", 32'(cnt_b), 0);
        check("sclr_serout_b", 32'({sol_b, sor_b}), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
